// File: rtl/button_pkg.sv
// Shared types and sizing helper for the button_debounce block.
package button_pkg;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PWAIT = 2'd1,
    HELD  = 2'd2,
    RWAIT = 2'd3
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 120000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 6000000;

  // One counter width covers both the debounce and the hold interval.
  function automatic int cnt_width(input int debounce_cycles, input int long_press_cycles);
    int max_cycles;
    max_cycles = (debounce_cycles > long_press_cycles) ? debounce_cycles : long_press_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button pins and conditioned outputs of button_debounce, bundled with master/slave views.
interface button_debounce_if #(
  parameter int NUM_BUTTONS = 3
);
  logic [NUM_BUTTONS-1:0] button_i;
  logic [NUM_BUTTONS-1:0] pressed_o;
  logic [NUM_BUTTONS-1:0] press_o;
  logic [NUM_BUTTONS-1:0] release_o;
  logic [NUM_BUTTONS-1:0] long_press_o;

  modport master (
    output button_i,
    input  pressed_o,
    input  press_o,
    input  release_o,
    input  long_press_o
  );

  modport slave (
    input  button_i,
    output pressed_o,
    output press_o,
    output release_o,
    output long_press_o
  );
endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchronizer, REL/PWAIT/HELD/RWAIT debounce FSM, registered strobes.
// Optional hold counter and long-press strobe when BUTTON_LONG_PRESS_EN is defined.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic pin,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  // The wait-state entry edge is count 0, so the accepting edge is the one that
  // would take the count to DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 2);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             sync1_r;
  logic             sync2_r;
  btn_state_t       state_r;
  btn_state_t       state_n;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n;
  logic             press_n;
  logic             release_n;
  logic             press_r;
  logic             release_r;
  logic             pressed_r;

  // Two-flop synchronizer; idles at 1 (released) through reset.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= pin;
      sync2_r <= sync1_r;
    end
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state_r)
      REL: begin
        cnt_n = {CNT_W{1'b0}};
        if (!sync2_r) state_n = PWAIT;
        else          state_n = REL;
      end
      PWAIT: begin
        if (sync2_r) begin
          state_n = REL;
          cnt_n   = {CNT_W{1'b0}};
        end else if (cnt_r == DB_TERM) begin
          state_n = HELD;
          cnt_n   = {CNT_W{1'b0}};
          press_n = 1'b1;
        end else begin
          cnt_n = sat_inc(cnt_r);
        end
      end
      HELD: begin
        cnt_n = {CNT_W{1'b0}};
        if (sync2_r) state_n = RWAIT;
        else         state_n = HELD;
      end
      RWAIT: begin
        if (!sync2_r) begin
          state_n = HELD;
          cnt_n   = {CNT_W{1'b0}};
        end else if (cnt_r == DB_TERM) begin
          state_n   = REL;
          cnt_n     = {CNT_W{1'b0}};
          release_n = 1'b1;
        end else begin
          cnt_n = sat_inc(cnt_r);
        end
      end
      default: begin
        state_n = REL;
        cnt_n   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= REL;
      cnt_r     <= {CNT_W{1'b0}};
      press_r   <= 1'b0;
      release_r <= 1'b0;
      pressed_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      press_r   <= press_n;
      release_r <= release_n;
      pressed_r <= (state_r == HELD) || (state_r == RWAIT);
    end
  end

  assign pressed       = pressed_r;
  assign press         = press_r;
  assign release_pulse = release_r;

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [CNT_W-1:0] hold_r;
  logic             long_r;
  logic             holding_s;

  assign holding_s = (state_r == HELD) || (state_r == RWAIT);

  // Hold counter runs through HELD and RWAIT; saturation keeps the match to one pulse per press.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_r <= {CNT_W{1'b0}};
      long_r <= 1'b0;
    end else begin
      if (!holding_s || (state_n == REL)) hold_r <= {CNT_W{1'b0}};
      else                                hold_r <= sat_inc(hold_r);
      long_r <= holding_s && (hold_r == LP_TERM);
    end
  end

  assign long_press = long_r;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Top of the button input-conditioning stage: one debounce_channel per button pin.
// Long-press detection is built only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce #(
  parameter int NUM_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int LONG_PRESS_CYCLES = 6000000
) (
  input logic              clk,
  input logic              rst_n_i,
  button_debounce_if.slave bus
);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst_n_i       (rst_n_i),
      .pin           (bus.button_i[g]),
      .pressed       (bus.pressed_o[g]),
      .press         (bus.press_o[g]),
      .release_pulse (bus.release_o[g]),
      .long_press    (bus.long_press_o[g])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: vector table plus hand-written bounce/long-press/reset sequences.
`timescale 1ns/1ps
module tb_button_debounce;

  localparam int NB = 3;
  localparam int DB = 8;
  localparam int LP = 32;
`ifdef BUTTON_LONG_PRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  button_debounce_if #(.NUM_BUTTONS(NB)) bus ();

  button_debounce #(
    .NUM_BUTTONS       (NB),
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP)
  ) dut (
    .clk     (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0] btn;
    int         n;
    logic [2:0] pressed;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lng;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int rc;
    int lc;

    // 1: reset with all buttons held down
    rst_n = 1'b0;
    bus.button_i = 3'b000;
    repeat (3) tick();
    check("rst_pressed", bus.pressed_o, 3'b000);
    check("rst_press", bus.press_o, 3'b000);
    check("rst_release", bus.release_o, 3'b000);
    check("rst_long", bus.long_press_o, 3'b000);
    rst_n = 1'b1;

    // reset release, simultaneous release/press, clean press/release on channel 1
    vecs.push_back('{btn:3'b000, n:9,  pressed:3'b000, press:3'b000, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b000, n:1,  pressed:3'b000, press:3'b111, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b000, n:1,  pressed:3'b111, press:3'b000, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b111, n:10, pressed:3'b111, press:3'b000, rel:3'b111, lng:3'b000});
    vecs.push_back('{btn:3'b111, n:1,  pressed:3'b000, press:3'b000, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b000, n:10, pressed:3'b000, press:3'b111, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b000, n:1,  pressed:3'b111, press:3'b000, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b111, n:10, pressed:3'b111, press:3'b000, rel:3'b111, lng:3'b000});
    vecs.push_back('{btn:3'b111, n:1,  pressed:3'b000, press:3'b000, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b101, n:10, pressed:3'b000, press:3'b010, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b101, n:1,  pressed:3'b010, press:3'b000, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b101, n:9,  pressed:3'b010, press:3'b000, rel:3'b000, lng:3'b000});
    vecs.push_back('{btn:3'b111, n:10, pressed:3'b010, press:3'b000, rel:3'b010, lng:3'b000});
    vecs.push_back('{btn:3'b111, n:1,  pressed:3'b000, press:3'b000, rel:3'b000, lng:3'b000});

    for (int i = 0; i < vecs.size(); i++) begin
      bus.button_i = vecs[i].btn;
      for (int k = 0; k < vecs[i].n; k++) begin
        tick();
        if (k < vecs[i].n - 1)
          check($sformatf("vec%0d_quiet", i), bus.press_o | bus.release_o | bus.long_press_o, 3'b000);
      end
      check($sformatf("vec%0d_pressed", i), bus.pressed_o, vecs[i].pressed);
      check($sformatf("vec%0d_press", i), bus.press_o, vecs[i].press);
      check($sformatf("vec%0d_release", i), bus.release_o, vecs[i].rel);
      check($sformatf("vec%0d_long", i), bus.long_press_o, vecs[i].lng);
    end

    // 2: bounce on channel 0, then a steady press
    pc = 0;
    rc = 0;
    for (int s = 0; s < 10; s++) begin
      bus.button_i = (s % 2 == 0) ? 3'b110 : 3'b111;
      repeat (3) begin
        tick();
        pc += int'(bus.press_o[0]);
        rc += int'(bus.release_o[0]);
      end
    end
    bus.button_i = 3'b110;
    for (int k = 1; k <= 9; k++) begin
      tick();
      pc += int'(bus.press_o[0]);
      rc += int'(bus.release_o[0]);
    end
    check("bounce_early_press", pc, 0);
    tick();
    check("bounce_press", bus.press_o, 3'b001);
    pc = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      pc += int'(bus.press_o[0]);
      rc += int'(bus.release_o[0]);
    end
    check("bounce_extra_press", pc, 0);
    check("bounce_release", rc, 0);
    check("bounce_pressed", bus.pressed_o, 3'b001);
    bus.button_i = 3'b111;
    repeat (10) tick();
    check("bounce_rel_strobe", bus.release_o, 3'b001);
    tick();
    check("bounce_rel_level", bus.pressed_o, 3'b000);

    // 5: long hold on channel 2
    bus.button_i = 3'b011;
    lc = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 10) check("long_press_strobe", bus.press_o, 3'b100);
      if (k == 41) check("long_before", bus.long_press_o, 3'b000);
      if (k == 42) check("long_at_32", int'(bus.long_press_o[2]), EXP_LONG);
      lc += int'(bus.long_press_o[2]);
    end
    bus.button_i = 3'b111;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) check("long_rel_strobe", bus.release_o, 3'b100);
      lc += int'(bus.long_press_o[2]);
    end
    check("long_count", lc, EXP_LONG);
    check("long_rel_level", bus.pressed_o, 3'b000);

    // 6: reset while channel 0 is mid-debounce (count 5)
    bus.button_i = 3'b110;
    repeat (8) tick();
    check("midrst_before", bus.press_o, 3'b000);
    rst_n = 1'b0;
    #1;
    check("midrst_async_pressed", bus.pressed_o, 3'b000);
    pc = 0;
    repeat (3) begin
      tick();
      pc += int'(bus.press_o[0]);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      pc += int'(bus.press_o[0]);
    end
    check("midrst_no_press", pc, 0);
    tick();
    check("midrst_press", bus.press_o, 3'b001);
    tick();
    check("midrst_pressed", bus.pressed_o, 3'b001);
    bus.button_i = 3'b111;
    repeat (10) tick();
    check("midrst_release", bus.release_o, 3'b001);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
